// File: rtl/tcp_tx_stream_gen.sv
// rtl/tcp_tx_stream_gen.sv - segmenting TCP TX traffic generator with status-driven retry
module tcp_tx_stream_gen #(
    parameter int  DATA_W    = 512,
    parameter int  MAX_RETRY = 4,
    parameter int  RETRY_GAP = 64,
    localparam int KEEP_W    = DATA_W / 8
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              start,
    input  logic [15:0]       cfg_session,
    input  logic [63:0]       cfg_total_bytes,
    input  logic [15:0]       cfg_pkt_len,
    output logic              m_tx_meta_valid,
    input  logic              m_tx_meta_ready,
    output logic [31:0]       m_tx_meta_data,
    output logic              m_tx_data_valid,
    input  logic              m_tx_data_ready,
    output logic [DATA_W-1:0] m_tx_data_data,
    output logic [KEEP_W-1:0] m_tx_data_keep,
    output logic              m_tx_data_last,
    input  logic              s_tx_status_valid,
    output logic              s_tx_status_ready,
    input  logic [63:0]       s_tx_status_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [63:0]       bytes_sent,
    output logic [31:0]       pkts_sent,
    output logic [31:0]       retries,
    output logic [63:0]       tx_cycles
);

    localparam int KEEP_LOG = $clog2(KEEP_W);
    localparam int LANES    = DATA_W / 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_META,
        S_DATA,
        S_WAIT_STS,
        S_GAP,
        S_FINISH
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [15:0] r_session;
    logic [63:0] r_total;
    logic [15:0] r_pkt_len;
    logic [15:0] r_cur_len;
    logic [15:0] r_beats;
    logic [15:0] r_beat_idx;
    logic [15:0] r_gap_cnt;
    logic [7:0]  r_retry_cnt;
    logic        r_error;
    logic [63:0] r_bytes_sent;
    logic [31:0] r_pkts_sent;
    logic [31:0] r_retries;
    logic [63:0] r_tx_cycles;

    logic [63:0]         w_remain;
    logic [63:0]         w_new_bytes;
    logic [15:0]         w_cur_len;
    logic [15:0]         w_beats;
    logic [KEEP_LOG-1:0] w_rem;
    logic [KEEP_W-1:0]   w_keep_last;
    logic                w_last_beat;
    logic                w_start_acc;
    logic                w_meta_hs;
    logic                w_data_hs;
    logic                w_sts_hs;
    logic                w_sts_match;
    logic                w_sts_ok;
    logic                w_busy;
    logic                w_unused_sts;

    // Packet sizing: the final packet shrinks to whatever is left of the total.
    assign w_remain    = r_total - r_bytes_sent;
    assign w_cur_len   = (w_remain < {48'd0, r_pkt_len}) ? w_remain[15:0] : r_pkt_len;
    assign w_beats     = (w_cur_len >> KEEP_LOG) + {15'd0, |w_cur_len[KEEP_LOG-1:0]};
    assign w_new_bytes = r_bytes_sent + {48'd0, r_cur_len};
    assign w_rem       = r_cur_len[KEEP_LOG-1:0];
    assign w_last_beat = (r_beat_idx == r_beats - 16'd1);

    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_meta_hs   = (r_state == S_META) && m_tx_meta_ready;
    assign w_data_hs   = (r_state == S_DATA) && m_tx_data_ready;
    assign w_sts_hs    = (r_state == S_WAIT_STS) && s_tx_status_valid;
    assign w_sts_match = (s_tx_status_data[15:0] == r_session);
    assign w_sts_ok    = (s_tx_status_data[63:61] == 3'd0);
    assign w_busy      = (r_state == S_META) || (r_state == S_DATA) ||
                         (r_state == S_WAIT_STS) || (r_state == S_GAP);

    // The echoed length and reserved status bits carry no information we act on.
    assign w_unused_sts = &{1'b0, s_tx_status_data[60:16]};

    assign busy       = w_busy;
    assign error      = r_error;
    assign bytes_sent = r_bytes_sent;
    assign pkts_sent  = r_pkts_sent;
    assign retries    = r_retries;
    assign tx_cycles  = r_tx_cycles;

    // Byte enables of a short final beat: the low (cur_len mod KEEP_W) bytes, or all when it divides evenly.
    always_comb begin
        w_keep_last = '1;
        if (w_rem != '0) begin
            for (int i = 0; i < KEEP_W; i++) begin
                w_keep_last[i] = (KEEP_LOG'(i) < w_rem);
            end
        end
    end

    // State register; reset drops every valid immediately since they decode from state.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs; everything is decoded from registers, never from ready.
    always_comb begin
        w_next            = r_state;
        m_tx_meta_valid   = 1'b0;
        m_tx_meta_data    = 32'd0;
        m_tx_data_valid   = 1'b0;
        m_tx_data_data    = '0;
        m_tx_data_keep    = '0;
        m_tx_data_last    = 1'b0;
        s_tx_status_ready = 1'b0;
        done              = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (cfg_total_bytes == 64'd0) begin
                        w_next = S_FINISH;
                    end else if (cfg_pkt_len != 16'd0) begin
                        w_next = S_META;
                    end
                end
            end
            S_META: begin
                m_tx_meta_valid = 1'b1;
                m_tx_meta_data  = {w_cur_len, r_session};
                if (m_tx_meta_ready) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                m_tx_data_valid = 1'b1;
                m_tx_data_data  = {LANES{r_pkts_sent[15:0], r_beat_idx}};
                m_tx_data_keep  = w_last_beat ? w_keep_last : '1;
                m_tx_data_last  = w_last_beat;
                if (m_tx_data_ready && w_last_beat) begin
                    w_next = S_WAIT_STS;
                end
            end
            S_WAIT_STS: begin
                s_tx_status_ready = 1'b1;
                if (s_tx_status_valid && w_sts_match) begin
                    if (w_sts_ok) begin
                        w_next = (w_new_bytes == r_total) ? S_FINISH : S_META;
                    end else if (r_retry_cnt == 8'(MAX_RETRY)) begin
                        w_next = S_IDLE;
                    end else begin
                        w_next = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (r_gap_cnt == 16'(RETRY_GAP - 1)) begin
                    w_next = S_META;
                end
            end
            S_FINISH: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Job configuration, per-packet bookkeeping and the host-visible counters.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_session    <= 16'd0;
            r_total      <= 64'd0;
            r_pkt_len    <= 16'd0;
            r_cur_len    <= 16'd0;
            r_beats      <= 16'd0;
            r_beat_idx   <= 16'd0;
            r_gap_cnt    <= 16'd0;
            r_retry_cnt  <= 8'd0;
            r_error      <= 1'b0;
            r_bytes_sent <= 64'd0;
            r_pkts_sent  <= 32'd0;
            r_retries    <= 32'd0;
            r_tx_cycles  <= 64'd0;
        end else begin
            if (w_start_acc) begin
                r_session    <= cfg_session;
                r_total      <= cfg_total_bytes;
                r_pkt_len    <= cfg_pkt_len;
                r_bytes_sent <= 64'd0;
                r_pkts_sent  <= 32'd0;
                r_retries    <= 32'd0;
                r_tx_cycles  <= 64'd0;
                r_retry_cnt  <= 8'd0;
                r_error      <= (cfg_total_bytes != 64'd0) && (cfg_pkt_len == 16'd0);
            end
            if (w_busy) begin
                r_tx_cycles <= r_tx_cycles + 64'd1;
            end
            if (w_meta_hs) begin
                r_cur_len  <= w_cur_len;
                r_beats    <= w_beats;
                r_beat_idx <= 16'd0;
            end
            if (w_data_hs) begin
                r_beat_idx <= r_beat_idx + 16'd1;
            end
            if (w_sts_hs && w_sts_match) begin
                if (w_sts_ok) begin
                    r_bytes_sent <= w_new_bytes;
                    r_pkts_sent  <= r_pkts_sent + 32'd1;
                    r_retry_cnt  <= 8'd0;
                end else begin
                    r_retries <= r_retries + 32'd1;
                    if (r_retry_cnt == 8'(MAX_RETRY)) begin
                        r_error <= 1'b1;
                    end else begin
                        r_retry_cnt <= r_retry_cnt + 8'd1;
                    end
                end
            end
            r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 16'd1 : 16'd0;
        end
    end

endmodule

// File: tb/tb_tcp_tx_stream_gen.sv
// tb/tb_tcp_tx_stream_gen.sv - randomized self-checking bench for tcp_tx_stream_gen
module tb_tcp_tx_stream_gen;

    localparam int DATA_W    = 512;
    localparam int KEEP_W    = DATA_W / 8;
    localparam int MAX_RETRY = 4;
    localparam int RETRY_GAP = 64;
    localparam int LIMIT     = 20000;

    logic              aclk = 1'b0;
    logic              areset;
    logic              start;
    logic [15:0]       cfg_session;
    logic [63:0]       cfg_total_bytes;
    logic [15:0]       cfg_pkt_len;
    logic              m_tx_meta_valid;
    logic              m_tx_meta_ready;
    logic [31:0]       m_tx_meta_data;
    logic              m_tx_data_valid;
    logic              m_tx_data_ready;
    logic [DATA_W-1:0] m_tx_data_data;
    logic [KEEP_W-1:0] m_tx_data_keep;
    logic              m_tx_data_last;
    logic              s_tx_status_valid;
    logic              s_tx_status_ready;
    logic [63:0]       s_tx_status_data;
    logic              busy;
    logic              done;
    logic              error;
    logic [63:0]       bytes_sent;
    logic [31:0]       pkts_sent;
    logic [31:0]       retries;
    logic [63:0]       tx_cycles;

    int n_checks = 0;
    int n_errors = 0;

    tcp_tx_stream_gen #(
        .DATA_W   (DATA_W),
        .MAX_RETRY(MAX_RETRY),
        .RETRY_GAP(RETRY_GAP)
    ) dut (
        .aclk             (aclk),
        .areset           (areset),
        .start            (start),
        .cfg_session      (cfg_session),
        .cfg_total_bytes  (cfg_total_bytes),
        .cfg_pkt_len      (cfg_pkt_len),
        .m_tx_meta_valid  (m_tx_meta_valid),
        .m_tx_meta_ready  (m_tx_meta_ready),
        .m_tx_meta_data   (m_tx_meta_data),
        .m_tx_data_valid  (m_tx_data_valid),
        .m_tx_data_ready  (m_tx_data_ready),
        .m_tx_data_data   (m_tx_data_data),
        .m_tx_data_keep   (m_tx_data_keep),
        .m_tx_data_last   (m_tx_data_last),
        .s_tx_status_valid(s_tx_status_valid),
        .s_tx_status_ready(s_tx_status_ready),
        .s_tx_status_data (s_tx_status_data),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .bytes_sent       (bytes_sent),
        .pkts_sent        (pkts_sent),
        .retries          (retries),
        .tx_cycles        (tx_cycles)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Expected payload: every 32-bit lane holds {packet index, beat index}.
    function automatic logic [DATA_W-1:0] pat(input int p, input int b);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int l = 0; l < DATA_W / 32; l++) begin
            r[32*l +: 32] = {p[15:0], b[15:0]};
        end
        return r;
    endfunction

    // One job: mode 0 all OK, 1 first real status errors, 2 every real status errors.
    task automatic run_xfer(input logic [15:0] sess, input logic [63:0] total, input logic [15:0] plen,
                            input int mode, input int bp, input bit poke);
        int          cyc = 0;
        int          done_cyc = -1;
        int          abort_cyc = -1;
        int          err_cyc = -1;
        int          n_metas = 0;
        int          exp_metas = 0;
        int          exp_pkt = 0;
        int          attempts = 0;
        int          exp_retries = 0;
        int          nb = 0;
        int          beat = 0;
        int          sts_delay = 0;
        int          extra_done = 0;
        logic [63:0] exp_offs = 64'd0;
        logic [15:0] exp_len;
        logic [63:0] mask;
        logic [31:0] meta_hold = 32'd0;
        logic [DATA_W-1:0] data_hold = '0;
        logic [KEEP_W:0]   kl_hold = '0;
        bit gap_chk = 0;
        bit meta_stall = 0;
        bit data_stall = 0;
        bit sts_pend = 0;
        bit sts_wrong = 0;
        bit first_sts = 1;
        bit cur_err = 0;
        bit finished = 0;

        cfg_session     = sess;
        cfg_total_bytes = total;
        cfg_pkt_len     = plen;
        start           = 1'b1;
        if (total == 64'd0) done_cyc = 1;
        else if (plen == 16'd0) abort_cyc = 1;
        else exp_metas = 1;
        step();
        cyc             = 1;
        start           = 1'b0;
        cfg_session     = 16'($urandom);
        cfg_total_bytes = {32'($urandom), 32'($urandom)};
        cfg_pkt_len     = 16'($urandom);

        while (1) begin
            if (done) begin
                check("done_cycle", cyc, done_cyc);
                check("done_busy", busy, 1'b0);
                finished = 1;
            end
            if (cyc == abort_cyc) begin
                check("abort_error", error, 1'b1);
                check("abort_busy", busy, 1'b0);
                finished = 1;
            end
            if (finished || cyc >= LIMIT) break;

            exp_len = ((total - exp_offs) < {48'd0, plen}) ? 16'(total - exp_offs) : plen;
            start   = (poke && cyc == 3);

            if (meta_stall) check("meta_held", m_tx_meta_valid, 1'b1);
            if (m_tx_meta_valid) begin
                if (meta_stall) check("meta_stable", m_tx_meta_data, meta_hold);
                if (gap_chk) begin
                    check("retry_gap", cyc - err_cyc, RETRY_GAP + 1);
                    gap_chk = 0;
                end
                m_tx_meta_ready = ($urandom_range(99) >= bp);
                if (m_tx_meta_ready) begin
                    check("meta", m_tx_meta_data, {exp_len, sess});
                    check("sts_ready_low", s_tx_status_ready, 1'b0);
                    n_metas++;
                    nb         = (int'(exp_len) + 63) / 64;
                    beat       = 0;
                    meta_stall = 0;
                end else begin
                    meta_stall = 1;
                    meta_hold  = m_tx_meta_data;
                end
            end else begin
                meta_stall      = 0;
                m_tx_meta_ready = ($urandom_range(99) >= bp);
            end

            if (data_stall) check("data_held", m_tx_data_valid, 1'b1);
            if (m_tx_data_valid) begin
                if (data_stall) begin
                    check("data_stable", m_tx_data_data, data_hold);
                    check("keep_last_stable", {m_tx_data_keep, m_tx_data_last}, kl_hold);
                end
                m_tx_data_ready = ($urandom_range(99) >= bp);
                if (m_tx_data_ready) begin
                    mask = (beat == nb - 1 && exp_len[5:0] != 6'd0) ?
                           ((64'd1 << exp_len[5:0]) - 64'd1) : '1;
                    check("beat_in_range", beat < nb, 1'b1);
                    check("beat_data", m_tx_data_data, pat(exp_pkt, beat));
                    check("beat_keep", m_tx_data_keep, mask);
                    check("beat_last", m_tx_data_last, beat == nb - 1);
                    beat++;
                    if (beat == nb) begin
                        sts_pend  = 1;
                        sts_delay = $urandom_range(3);
                        sts_wrong = ($urandom_range(3) == 0);
                    end
                    data_stall = 0;
                end else begin
                    data_stall = 1;
                    data_hold  = m_tx_data_data;
                    kl_hold    = {m_tx_data_keep, m_tx_data_last};
                end
            end else begin
                data_stall      = 0;
                m_tx_data_ready = ($urandom_range(99) >= bp);
            end

            if (sts_pend && sts_delay > 0) begin
                sts_delay--;
                s_tx_status_valid = 1'b0;
            end else if (sts_pend) begin
                s_tx_status_valid = 1'b1;
                if (sts_wrong) begin
                    s_tx_status_data = {3'($urandom_range(7)), 29'd0, exp_len, sess ^ 16'h0001};
                end else begin
                    cur_err = (mode == 2) || (mode == 1 && first_sts);
                    s_tx_status_data = {cur_err ? 3'($urandom_range(7, 1)) : 3'd0, 29'd0, exp_len, sess};
                end
                if (s_tx_status_ready) begin
                    if (sts_wrong) begin
                        sts_wrong = 0;
                    end else begin
                        sts_pend  = 0;
                        first_sts = 0;
                        if (!cur_err) begin
                            exp_offs = exp_offs + {48'd0, exp_len};
                            exp_pkt++;
                            attempts = 0;
                            if (exp_offs == total) done_cyc = cyc + 1;
                            else exp_metas++;
                        end else begin
                            exp_retries++;
                            attempts++;
                            if (attempts > MAX_RETRY) begin
                                abort_cyc = cyc + 1;
                            end else begin
                                exp_metas++;
                                err_cyc = cyc;
                                gap_chk = 1;
                            end
                        end
                    end
                end
            end else begin
                s_tx_status_valid = 1'b0;
            end

            step();
            cyc++;
        end

        check("completed", finished, 1'b1);
        check("bytes_sent", bytes_sent, exp_offs);
        check("pkts_sent", pkts_sent, exp_pkt);
        check("retries", retries, exp_retries);
        check("error_flag", error, abort_cyc >= 0);
        check("meta_count", n_metas, exp_metas);
        check("tx_cycles", tx_cycles, cyc - 1);

        start             = 1'b0;
        s_tx_status_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done || busy) extra_done++;
        end
        check("quiet_after", extra_done, 0);
    endtask

    // Launch a long job, then hit reset in the middle of the payload.
    task automatic reset_midstream();
        int guard = 0;
        int beats = 0;
        int noisy = 0;
        cfg_session     = 16'h0022;
        cfg_total_bytes = 64'd4096;
        cfg_pkt_len     = 16'd1024;
        start           = 1'b1;
        step();
        start           = 1'b0;
        m_tx_meta_ready = 1'b1;
        m_tx_data_ready = 1'b1;
        while (beats < 3 && guard < 100) begin
            if (m_tx_data_valid) beats++;
            step();
            guard++;
        end
        check("rst_reached_data", m_tx_data_valid, 1'b1);
        m_tx_data_ready = 1'b0;
        #3;
        areset = 1'b1;
        #1;
        check("rst_async_flags", {m_tx_meta_valid, m_tx_data_valid, s_tx_status_ready, busy, done, error}, 6'd0);
        check("rst_counters", {bytes_sent, pkts_sent, retries, tx_cycles}, 192'd0);
        check("rst_side", {m_tx_data_keep, m_tx_data_last, m_tx_meta_data}, 97'd0);
        check("rst_payload", m_tx_data_data, 512'd0);
        step();
        step();
        areset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done || busy || m_tx_meta_valid || m_tx_data_valid) noisy++;
        end
        check("rst_idle_after", noisy, 0);
    endtask

    initial begin
        areset            = 1'b1;
        start             = 1'b0;
        cfg_session       = 16'd0;
        cfg_total_bytes   = 64'd0;
        cfg_pkt_len       = 16'd0;
        m_tx_meta_ready   = 1'b0;
        m_tx_data_ready   = 1'b0;
        s_tx_status_valid = 1'b0;
        s_tx_status_data  = 64'd0;
        step();
        step();
        check("reset_flags", {m_tx_meta_valid, m_tx_data_valid, s_tx_status_ready, busy, done, error}, 6'd0);
        check("reset_counters", {bytes_sent, pkts_sent, retries, tx_cycles}, 192'd0);
        check("reset_side", {m_tx_data_keep, m_tx_data_last, m_tx_meta_data}, 97'd0);
        areset = 1'b0;
        step();

        run_xfer(16'd5, 64'd256, 16'd128, 0, 0, 0);
        run_xfer(16'd7, 64'd200, 16'd128, 0, 0, 0);
        run_xfer(16'd11, 64'd10, 16'd3, 0, 0, 0);
        run_xfer(16'd12, 64'd640, 16'd640, 0, 20, 0);
        for (int i = 0; i < 6; i++) begin
            run_xfer(16'($urandom), 64'($urandom_range(3000, 1)), 16'($urandom_range(1500, 64)), 0, 50, 1);
        end
        run_xfer(16'd9, 64'd500, 16'd192, 1, 30, 0);
        run_xfer(16'd3, 64'd300, 16'd100, 2, 0, 0);
        run_xfer(16'd4, 64'd100, 16'd0, 0, 0, 0);
        run_xfer(16'd6, 64'd0, 16'd64, 0, 0, 0);
        reset_midstream();
        run_xfer(16'd13, 64'd256, 16'd128, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
